// File: rtl/reg_access_master.sv
// ---------------------------------------------------------------------------
// reg_access_master
//
// Command-side bus master for the switch's 8-bit register bank. Register
// commands from the CPU side are buffered in a small FIFO and executed one at
// a time as a single sel_en/ack handshake on the bank. Every command produces
// exactly one response, in order: read data for reads, nothing for writes, or
// an error flag when the address is outside the implemented register range.
//
// Optional feature macro: REG_ACC_TIMEOUT_EN
//   When defined, an access that sees no ack within TIMEOUT_CYC cycles is
//   abandoned and answered with rsp_err=1. When undefined, the master waits
//   for ack indefinitely.
//
// Parameters
//   NUM_OF_REG   registers implemented downstream (legal addr 0..NUM_OF_REG-1)
//   FIFO_DEPTH   command FIFO entries (power of two, >= 2)
//   TIMEOUT_CYC  ack wait limit in cycles (only with REG_ACC_TIMEOUT_EN)
//
// Ports
//   clk, rst_n                       clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready              command handshake
//   cmd_wr, cmd_addr, cmd_wdata      command contents (1=write)
//   rsp_valid/rsp_ready              response handshake, response held until taken
//   rsp_wr, rsp_rdata, rsp_err       response contents
//   sel_en, wr_rd_s, addr, wr_data   bank request side
//   rd_data, ack                     bank reply side (ack registered in the bank)
//   busy                             FSM active or commands still queued
// ---------------------------------------------------------------------------
module reg_access_master #(
  parameter int NUM_OF_REG  = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_wr,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_wr,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       sel_en,
  output logic       wr_rd_s,
  output logic [7:0] addr,
  output logic [7:0] wr_data,
  input  logic [7:0] rd_data,
  input  logic       ack,
  output logic       busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  // 9 bits so that NUM_OF_REG=256 (every address legal) still compares correctly
  localparam logic [8:0] NUM_REG_LIM = 9'(NUM_OF_REG);

  // Reject parameter sets the pointer arithmetic and counters cannot handle
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      NUM_OF_REG < 1 || NUM_OF_REG > 256 ||
      TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_params
    $error("reg_access_master: unsupported parameter values");
  end

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RELEASE,
    RESP
  } state_t;

  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
  } cmd_t;

  cmd_t             fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             pop;
  cmd_t             head;
  logic             addr_ok;

  state_t           state;
  state_t           state_nxt;

  logic             work_wr;
  logic [7:0]       work_addr;
  logic [7:0]       work_wdata;
  logic [7:0]       rdata_q;
  logic             err_q;
  logic             tmo_hit;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign head       = fifo_mem[rd_ptr];
  assign addr_ok    = ({1'b0, head.addr} < NUM_REG_LIM);

  // The head is only taken while idle with the response slot free, so at
  // most one command is ever in flight and responses stay in order.
  assign pop       = (state == IDLE) && !fifo_empty && !rsp_valid;
  // A full FIFO can still accept when the head leaves in the same cycle.
  assign cmd_ready = !fifo_full || pop;
  assign push      = cmd_valid && cmd_ready;

  // Command storage; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{wr: cmd_wr, addr: cmd_addr, wdata: cmd_wdata};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

`ifdef REG_ACC_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] tmo_cnt;

  // Counts ACCESS cycles; it is zero on the first cycle of every access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state != ACCESS) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign tmo_hit = (state == ACCESS) && !ack && (tmo_cnt == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. RELEASE waits for ack to fall so a lingering ack from
  // this access can never be mistaken for the next command's ack.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pop) begin
          state_nxt = addr_ok ? ACCESS : RESP;
        end
      end
      ACCESS: begin
        if (ack || tmo_hit) begin
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (!ack) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Work registers: the popped command plus the response being built for it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_wr    <= 1'b0;
      work_addr  <= '0;
      work_wdata <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (pop) begin
        work_wr    <= head.wr;
        work_addr  <= head.addr;
        work_wdata <= head.wdata;
        rdata_q    <= '0;
        err_q      <= !addr_ok;
      end else if (state == ACCESS) begin
        if (ack) begin
          if (!work_wr) begin
            rdata_q <= rd_data;
          end
        end else if (tmo_hit) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  // sel_en drops in the cycle ack arrives: ack comes from a bank register, so
  // this stays glitch-free and lets ack fall one cycle earlier, giving the
  // five-cycle command turnaround.
  assign sel_en    = (state == ACCESS) && !ack;
  assign wr_rd_s   = work_wr;
  assign addr      = work_addr;
  assign wr_data   = work_wdata;

  assign rsp_valid = (state == RESP);
  assign rsp_wr    = work_wr;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  assign busy      = (state != IDLE) || !fifo_empty;

endmodule
